event_replayer: RTL

Hardware stimulus source for a generated RTLola monitor. It drives each monitor input stream as a value bus plus a one-cycle `new_input_i` strobe. Timed event records are loaded through a ready/valid port into an internal FIFO. Once started, each record is replayed at its programmed cycle offset. It sits directly in front of `topEntity` and replaces the procedural stimulus used in simulation benches, so traces can be replayed on FPGA.

---
 rtl/event_replayer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/event_replayer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | event_replayer: replays timed two-stream event records from a FIFO as      |
// | value buses plus one-cycle strobes for a generated RTLola monitor.         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module event_replayer #(
  parameter int DATA_W  = 64,
  parameter int DELTA_W = 32,
  parameter int DEPTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [DELTA_W-1:0]        ld_delta,
  input  logic [1:0]                ld_mask,
  input  logic signed [DATA_W-1:0]  ld_data0,
  input  logic signed [DATA_W-1:0]  ld_data1,
  input  logic                      start,
  input  logic                      stop,
  output logic signed [DATA_W-1:0]  input_0,
  output logic signed [DATA_W-1:0]  input_1,
  output logic                      new_input_0,
  output logic                      new_input_1,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DELTA_W-1:0] delta;
    logic [1:0]         mask;
    logic [DATA_W-1:0]  d0;
    logic [DATA_W-1:0]  d1;
  } rec_t;

  rec_t               mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  state_t             state_q, state_d;
  logic [DELTA_W-1:0] cnt_q, cnt_d;
  logic [1:0]         strobe_q, strobe_d;
  logic [DATA_W-1:0]  val0_q, val0_d;
  logic [DATA_W-1:0]  val1_q, val1_d;
  logic               done_q, done_d;

  logic               full;
  logic               push;
  rec_t               head;
  rec_t               ld_rec;
  logic [AW:0]        rd_next;
  logic [DELTA_W-1:0] nxt_delta;

  function automatic logic [DELTA_W-1:0] at_least_one(input logic [DELTA_W-1:0] d);
    return (d == '0) ? DELTA_W'(1) : d;
  endfunction

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign ld_ready = !full;
  assign push     = en && ld_valid && !full;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_next  = rd_ptr_q + 1'b1;
  assign ld_rec   = '{delta: ld_delta, mask: ld_mask, d0: ld_data0, d1: ld_data1};

  // With a single record left, its successor can only be the one being pushed now.
  assign nxt_delta = (count == CW'(1)) ? ld_delta : mem_q[rd_next[AW-1:0]].delta;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    val0_d   = val0_q;
    val1_d   = val1_q;
    done_d   = done_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (en) begin
      strobe_d = '0;
      val0_d   = '0;
      val1_d   = '0;
      done_d   = 1'b0;
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (stop) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && (count != '0)) begin
              cnt_d   = at_least_one(head.delta);
              state_d = S_WAIT;
            end
          end
          S_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == DELTA_W'(1)) begin
              rd_ptr_d = rd_next;
              strobe_d = head.mask;
              val0_d   = head.mask[0] ? head.d0 : '0;
              val1_d   = head.mask[1] ? head.d1 : '0;
              if ((count != CW'(1)) || push) begin
                cnt_d = at_least_one(nxt_delta);
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= ld_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      strobe_q <= '0;
      val0_q   <= '0;
      val1_q   <= '0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      val0_q   <= val0_d;
      val1_q   <= val1_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign new_input_0 = strobe_q[0];
  assign new_input_1 = strobe_q[1];
  assign input_0     = val0_q;
  assign input_1     = val1_q;
  assign busy        = (state_q == S_WAIT);
  assign done        = done_q;

endmodule
`default_nettype wire
